hps_input_ctrl: RTL and testbench
=================================

HPS_INPUT_CTRL -- requirements
Module: hps_input_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 Parameter N_WORDS SHALL default to 196 and set the number of 32-bit image words per frame (28x28 pixels, 4 pixels per word).
REQ-003 Parameter ADDR_W SHALL default to 8 and set the image-buffer address width.
REQ-004 Port: clk  in  1  system clock; every input and output is synchronous to it.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: hps_data  in  32  image word from the HPS PIO.
REQ-007 Port: hps_data_valid  in  1  HPS PIO toggle; each transition marks one new word.
REQ-008 Port: hps_start_conv  in  1  HPS request to start inference; acts on its rising edge.
REQ-009 Port: hps_logits_retrieved  in  1  HPS acknowledge of result or error; acts on its rising edge.
REQ-010 Port: hps_state  out  8  FSM state code, read back by the HPS.
REQ-011 Port: img_wr_en  out  1  image-buffer write strobe.
REQ-012 Port: img_wr_addr  out  ADDR_W  image-buffer word address.
REQ-013 Port: img_wr_data  out  32  image-buffer write data.
REQ-014 Port: conv_start  out  1  one-cycle start pulse to the CNN core.
REQ-015 Port: conv_done  in  1  CNN completion strobe.
REQ-016 Port: logits_in  in  320  CNN logits; logit k occupies [32k+31:32k].
REQ-017 Port: logits_out  out  320  latched logits presented to the HPS, same packing as logits_in.
REQ-018 Port: conv_cycles  out  32  inference duration counter for debug.

Function
REQ-019 The block SHALL hold registered copies of hps_data_valid, hps_start_conv and hps_logits_retrieved, and an event SHALL be flagged when an input differs from its copy (toggle) or goes from 0 to 1 (rising edge).
REQ-020 hps_state encoding SHALL be: IDLE=0x00, LOAD=0x01, READY=0x02, RUN=0x03, DONE=0x04, ERROR=0xEE.
REQ-021 In IDLE or LOAD, a toggle SHALL capture hps_data and the word counter on the same edge, and img_wr_en SHALL then be high for exactly one following cycle with img_wr_addr set to the counter and img_wr_data set to the captured word.
REQ-022 After each write the counter SHALL increment by one; IDLE SHALL move to LOAD on the first toggle.
REQ-023 The write at address N_WORDS-1 SHALL move the FSM to READY; the counter SHALL NOT wrap.
REQ-024 In READY, a start_conv rising edge SHALL assert conv_start for exactly one cycle, clear conv_cycles to 0, and move the FSM to RUN.
REQ-025 In RUN, conv_cycles SHALL increment by one per cycle and saturate at 0xFFFFFFFF.
REQ-026 In RUN, conv_done SHALL latch logits_in into logits_out, freeze conv_cycles, and move the FSM to DONE.
REQ-027 In DONE, a logits_retrieved rising edge SHALL clear the word counter and move the FSM to IDLE.
REQ-028 logits_out SHALL hold its value until the next conv_done latch; it is not cleared by returning to IDLE.
REQ-029 Protocol errors SHALL move the FSM to ERROR: a start_conv rising edge in IDLE or LOAD, or a toggle in READY.
REQ-030 If a toggle and a start_conv rising edge occur on the same edge in LOAD, ERROR SHALL take priority and no write SHALL occur.
REQ-031 In ERROR, a logits_retrieved rising edge SHALL clear the word counter and move the FSM to IDLE.
REQ-032 Toggles in RUN, DONE or ERROR SHALL be ignored (no write).
REQ-033 conv_done outside RUN SHALL be ignored.
REQ-034 A start_conv rising edge outside IDLE, LOAD or READY SHALL be ignored.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While reset is high on a clock edge, the block SHALL set: FSM=IDLE; hps_state=0x00; word counter=0; img_wr_en=0; img_wr_addr=0; img_wr_data=0; conv_start=0; logits_out=0; conv_cycles=0.
REQ-037 While reset is high on a clock edge, all three edge-detect copies SHALL be set to 0.
REQ-038 A reset asserted mid-frame or mid-RUN SHALL abort the operation with no further writes or pulses, and the next frame SHALL restart at address 0.

Verification
REQ-039 Scenario: 196 toggles with hps_data=i -> 196 single-cycle writes at addresses 0..195 carrying data i; hps_state=0x02 after the last write.
REQ-040 Scenario: in READY, start_conv rises; conv_done arrives 50 cycles later with logit k=k+1 -> one conv_start pulse; conv_cycles=50; logits_out holds 1..10; hps_state=0x04.
REQ-041 Scenario: in DONE, logits_retrieved rises -> hps_state=0x00; logits_out still 1..10; the next toggle writes address 0.
REQ-042 Scenario: start_conv rises after 10 words -> hps_state=0xEE with no conv_start; then logits_retrieved rises -> hps_state=0x00.
REQ-043 Scenario: in LOAD, a toggle and a start_conv rise on the same edge -> hps_state=0xEE and img_wr_en stays 0.
REQ-044 Scenario: reset for one cycle during RUN -> all outputs at reset values; a later conv_done is ignored.

Source files
------------

// File: rtl/hps_input_ctrl.sv
// HPS-facing front end for the CNN accelerator: collects one image frame from the
// HPS PIO into the image buffer, launches inference and hands the logits back.
module hps_input_ctrl #(
  parameter int N_WORDS = 196,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       hps_data,
  input  logic              hps_data_valid,
  input  logic              hps_start_conv,
  input  logic              hps_logits_retrieved,
  output logic [7:0]        hps_state,
  output logic              img_wr_en,
  output logic [ADDR_W-1:0] img_wr_addr,
  output logic [31:0]       img_wr_data,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [319:0]      logits_in,
  output logic [319:0]      logits_out,
  output logic [31:0]       conv_cycles
);

  // State codes double as the value the HPS reads back.
  typedef enum logic [7:0] {
    ST_IDLE  = 8'h00,
    ST_LOAD  = 8'h01,
    ST_READY = 8'h02,
    ST_RUN   = 8'h03,
    ST_DONE  = 8'h04,
    ST_ERROR = 8'hEE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_e            state_q, state_d;
  logic              valid_q, start_q, retr_q;
  logic [ADDR_W-1:0] wcnt_q;

  logic toggle, start_rise, retr_rise;
  logic do_write, do_start, do_latch, clr_cnt;

  // The PIO data-valid line is a toggle; the other two HPS controls act on rising edges.
  assign toggle     = hps_data_valid ^ valid_q;
  assign start_rise = hps_start_conv & ~start_q;
  assign retr_rise  = hps_logits_retrieved & ~retr_q;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    do_start = 1'b0;
    do_latch = 1'b0;
    clr_cnt  = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        // A premature start request wins over a simultaneous word.
        if (start_rise) begin
          state_d = ST_ERROR;
        end else if (toggle) begin
          do_write = 1'b1;
          state_d  = (wcnt_q == LAST_ADDR) ? ST_READY : ST_LOAD;
        end
      end
      ST_READY: begin
        if (toggle) begin
          state_d = ST_ERROR;
        end else if (start_rise) begin
          do_start = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (conv_done) begin
          do_latch = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (retr_rise) begin
          clr_cnt = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      retr_q      <= 1'b0;
      wcnt_q      <= '0;
      img_wr_en   <= 1'b0;
      img_wr_addr <= '0;
      img_wr_data <= '0;
      conv_start  <= 1'b0;
      logits_out  <= '0;
      conv_cycles <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= hps_data_valid;
      start_q   <= hps_start_conv;
      retr_q    <= hps_logits_retrieved;
      img_wr_en <= do_write;

      if (do_write) begin
        img_wr_addr <= wcnt_q;
        img_wr_data <= hps_data;
        wcnt_q      <= wcnt_q + 1'b1;
      end else if (clr_cnt) begin
        wcnt_q <= '0;
      end

      conv_start <= do_start;

      // Counts every cycle spent in RUN, including the completion cycle; frozen afterwards.
      if (do_start) begin
        conv_cycles <= '0;
      end else if (state_q == ST_RUN && conv_cycles != 32'hFFFF_FFFF) begin
        conv_cycles <= conv_cycles + 32'd1;
      end

      if (do_latch) begin
        logits_out <= logits_in;
      end
    end
  end

  assign hps_state = state_q;

endmodule

// File: tb/tb_hps_input_ctrl.sv
// Directed bench for hps_input_ctrl: frame load, inference run, result handoff,
// protocol errors and reset abort. Inputs change after negedge, outputs sampled at negedge.
module tb_hps_input_ctrl;

  localparam int N_WORDS = 196;
  localparam int ADDR_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       hps_data;
  logic              hps_data_valid;
  logic              hps_start_conv;
  logic              hps_logits_retrieved;
  logic [7:0]        hps_state;
  logic              img_wr_en;
  logic [ADDR_W-1:0] img_wr_addr;
  logic [31:0]       img_wr_data;
  logic              conv_start;
  logic              conv_done;
  logic [319:0]      logits_in;
  logic [319:0]      logits_out;
  logic [31:0]       conv_cycles;

  int n_vec = 0;
  int n_bad = 0;

  hps_input_ctrl #(.N_WORDS(N_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .hps_data             (hps_data),
    .hps_data_valid       (hps_data_valid),
    .hps_start_conv       (hps_start_conv),
    .hps_logits_retrieved (hps_logits_retrieved),
    .hps_state            (hps_state),
    .img_wr_en            (img_wr_en),
    .img_wr_addr          (img_wr_addr),
    .img_wr_data          (img_wr_data),
    .conv_start           (conv_start),
    .conv_done            (conv_done),
    .logits_in            (logits_in),
    .logits_out           (logits_out),
    .conv_cycles          (conv_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tog;
    bit          start;
    bit          retr;
    logic [31:0] data;
    logic [7:0]  exp_state;
    bit          exp_wr;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit tog, bit start, bit retr, logic [31:0] data,
                              logic [7:0] st, bit wr, logic [7:0] addr, logic [31:0] wdata);
    vec_t v;
    v.tog = tog; v.start = start; v.retr = retr; v.data = data;
    v.exp_state = st; v.exp_wr = wr; v.exp_addr = addr; v.exp_data = wdata;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_logits(string name, bit zero);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s[%0d]", name, k), logits_out[32*k +: 32], zero ? 64'd0 : 64'(k + 1));
  endtask

  // Sends one full frame with data = word index and checks each single-cycle write.
  task automatic load_frame();
    for (int i = 0; i < N_WORDS; i++) begin
      hps_data_valid = ~hps_data_valid;
      hps_data       = 32'(i);
      @(negedge clk);
      check("wr_en", 64'(img_wr_en), 64'd1);
      check("wr_addr", 64'(img_wr_addr), 64'(i));
      check("wr_data", 64'(img_wr_data), 64'(i));
      if (i == 0) check("state_load", 64'(hps_state), 64'h01);
      @(negedge clk);
      check("wr_pulse_end", 64'(img_wr_en), 64'd0);
    end
    check("state_ready", 64'(hps_state), 64'h02);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cs_cnt;

    reset = 1'b1;
    hps_data = '0;
    hps_data_valid = 1'b0;
    hps_start_conv = 1'b0;
    hps_logits_retrieved = 1'b0;
    conv_done = 1'b0;
    for (int k = 0; k < 10; k++) logits_in[32*k +: 32] = 32'(k + 1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 64'(hps_state), 64'h00);
    check("rst_wr_en", 64'(img_wr_en), 64'd0);
    check("rst_wr_addr", 64'(img_wr_addr), 64'd0);
    check("rst_wr_data", 64'(img_wr_data), 64'd0);
    check("rst_conv_start", 64'(conv_start), 64'd0);
    check("rst_conv_cycles", 64'(conv_cycles), 64'd0);
    check_logits("rst_logits", 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Full frame, then inference with done 50 cycles after the start edge
    load_frame();
    hps_start_conv = 1'b1;
    @(negedge clk);
    hps_start_conv = 1'b0;
    check("run_state", 64'(hps_state), 64'h03);
    check("run_cycles0", 64'(conv_cycles), 64'd0);
    cs_cnt = conv_start ? 1 : 0;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      if (conv_start) cs_cnt++;
    end
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    if (conv_start) cs_cnt++;
    check("conv_start_pulses", 64'(cs_cnt), 64'd1);
    check("done_state", 64'(hps_state), 64'h04);
    check("done_cycles", 64'(conv_cycles), 64'd50);
    check_logits("done_logits", 1'b0);
    @(negedge clk);
    check("cycles_frozen", 64'(conv_cycles), 64'd50);

    // Toggle in DONE is ignored
    hps_data_valid = ~hps_data_valid;
    @(negedge clk);
    check("done_tog_wr_en", 64'(img_wr_en), 64'd0);
    check("done_tog_state", 64'(hps_state), 64'h04);

    // Retrieve: back to IDLE, logits held, next word goes to address 0
    hps_logits_retrieved = 1'b1;
    @(negedge clk);
    check("retr_state", 64'(hps_state), 64'h00);
    check_logits("retr_logits", 1'b0);
    hps_logits_retrieved = 1'b0;
    hps_data_valid = ~hps_data_valid;
    hps_data = 32'h77;
    @(negedge clk);
    check("restart_wr_en", 64'(img_wr_en), 64'd1);
    check("restart_addr", 64'(img_wr_addr), 64'd0);
    check("restart_data", 64'(img_wr_data), 64'h77);
    check("restart_state", 64'(hps_state), 64'h01);
    @(negedge clk);

    // Table: early start after 10 words, recovery, collision of toggle and start in LOAD
    for (int k = 1; k < 10; k++) begin
      vecs.push_back(mk(1, 0, 0, 32'h100 + 32'(k), 8'h01, 1, 8'(k), 32'h100 + 32'(k)));
      vecs.push_back(mk(0, 0, 0, 32'h0,            8'h01, 0, 8'h0,  32'h0));
    end
    vecs.push_back(mk(0, 1, 0, 32'h0,  8'hEE, 0, 8'h0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,  8'hEE, 0, 8'h0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h0,  8'h00, 0, 8'h0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  8'h00, 0, 8'h0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h55, 8'h01, 1, 8'h0, 32'h55));
    vecs.push_back(mk(0, 0, 0, 32'h0,  8'h01, 0, 8'h0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h66, 8'hEE, 0, 8'h0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h67, 8'hEE, 0, 8'h0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h0,  8'h00, 0, 8'h0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  8'h00, 0, 8'h0, 32'h0));
    foreach (vecs[i]) begin
      if (vecs[i].tog) hps_data_valid = ~hps_data_valid;
      hps_data             = vecs[i].data;
      hps_start_conv       = vecs[i].start;
      hps_logits_retrieved = vecs[i].retr;
      @(negedge clk);
      check($sformatf("tbl[%0d].state", i), 64'(hps_state), 64'(vecs[i].exp_state));
      check($sformatf("tbl[%0d].wr_en", i), 64'(img_wr_en), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check($sformatf("tbl[%0d].addr", i), 64'(img_wr_addr), 64'(vecs[i].exp_addr));
        check($sformatf("tbl[%0d].data", i), 64'(img_wr_data), 64'(vecs[i].exp_data));
      end
      check($sformatf("tbl[%0d].conv_start", i), 64'(conv_start), 64'd0);
    end

    // Reset in the middle of RUN aborts; a later conv_done is ignored
    load_frame();
    hps_start_conv = 1'b1;
    @(negedge clk);
    hps_start_conv = 1'b0;
    check("run2_state", 64'(hps_state), 64'h03);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    hps_data_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", 64'(hps_state), 64'h00);
    check("abort_wr_en", 64'(img_wr_en), 64'd0);
    check("abort_wr_addr", 64'(img_wr_addr), 64'd0);
    check("abort_wr_data", 64'(img_wr_data), 64'd0);
    check("abort_conv_start", 64'(conv_start), 64'd0);
    check("abort_cycles", 64'(conv_cycles), 64'd0);
    check_logits("abort_logits", 1'b1);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    @(negedge clk);
    check("late_done_state", 64'(hps_state), 64'h00);
    check("late_done_cycles", 64'(conv_cycles), 64'd0);
    check_logits("late_done_logits", 1'b1);

    // New frame restarts at address 0; a toggle in READY is a protocol error
    load_frame();
    hps_data_valid = ~hps_data_valid;
    @(negedge clk);
    check("ready_tog_state", 64'(hps_state), 64'hEE);
    check("ready_tog_wr_en", 64'(img_wr_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
